// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit check and the parity_err output.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_W-1:0]     count,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 busy,
    output logic                 parity_err
`else
    output logic                 busy
`endif
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] TMR_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMR_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic w_rxs;
    logic w_tick;
    logic w_stop_smp;
    logic w_par_bad;
    logic w_push;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_rxs      = r_sync2;
    assign w_tick     = (r_timer == '0);
    assign w_stop_smp = (r_state == S_STOP) && w_tick;

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;

    assign w_par_bad  = ((^r_shift) ^ r_par) != PARITY_ODD;
    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
`endif

    // A good character is one whose stop bit is high and parity matches
    assign w_push = w_stop_smp && w_rxs && !w_par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_data;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (!w_tick) begin
                r_timer <= r_timer - 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_timer <= TMR_HALF;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_timer <= TMR_FULL;
                            r_idx   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_timer <= TMR_FULL;
                        if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_par   <= w_rxs;
                        r_timer <= TMR_FULL;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        // Frame error outranks a parity error
                        if (!w_rxs) begin
                            r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (w_par_bad) begin
                            r_parity_err <= 1'b1;
`endif
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop   = rd_en && !w_empty;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB      = 16;
    localparam int DB       = 8;
    localparam int DEPTH    = 16;
    localparam int PUSH_OFS = CPB / 2 + (DB + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          rd_en;
    logic [DB-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [4:0]    count;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int vectors = 0;
    int errs    = 0;
    int n_fe    = 0;
    int n_ov    = 0;
    int n_pe    = 0;
    logic [7:0] q[$];

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .busy      (busy),
        .parity_err(parity_err)
`else
        .busy      (busy)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) n_fe++;
        if (overrun === 1'b1) n_ov++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) n_pe++;
`endif
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stopb,
                        input logic par, input bit use_par);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (use_par) begin
            rx = par;
            repeat (CPB) @(negedge clk);
        end
        rx = stopb;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_read(input string tag);
        logic [7:0] e;
        if (q.size() == 0) begin
            vectors++;
            errs++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_data"}, 32'(rd_data), 32'(e));
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int fe0;
        int ov0;
        int k;
        bit seen;
        rst   = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", 32'({frame_err, overrun}), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single character, then pop it
        q.push_back(8'h41);
        send(8'h41, 1'b1, 1'b0, 1'b0);
        check("t1_empty", 32'(empty), 0);
        check("t1_count", 32'(count), 1);
        check("t1_errs", 32'(n_fe + n_ov), 0);
        do_read("t1_rd");
        check("t1_empty_after", 32'(empty), 1);
        check("t1_count_after", 32'(count), 0);

        // 2: 3-cycle glitch on idle line
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < CPB / 2 + 3; i++) begin
            if (busy) seen = 1'b1;
            @(negedge clk);
        end
        check("t2_busy_seen", 32'(seen), 1);
        check("t2_busy", 32'(busy), 0);
        check("t2_count", 32'(count), 0);
        check("t2_flags", 32'(n_fe + n_ov), 0);

        // 3: framing error then a clean character
        fe0 = n_fe;
        send(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("t3_frame_pulse", 32'(n_fe - fe0), 1);
        check("t3_count", 32'(count), 0);
        q.push_back(8'h0A);
        send(8'h0A, 1'b1, 1'b0, 1'b0);
        check("t3_count2", 32'(count), 1);
        do_read("t3_rd");

        // 4: overfill by one, then drain
        ov0 = n_ov;
        for (int i = 0; i <= DEPTH; i++) begin
            if (q.size() < DEPTH) q.push_back(8'(i));
            send(8'(i), 1'b1, 1'b0, 1'b0);
        end
        check("t4_full", 32'(full), 1);
        check("t4_count", 32'(count), 16);
        check("t4_overrun", 32'(n_ov - ov0), 1);
        for (int i = 0; i < DEPTH; i++) do_read("t4_rd");
        check("t4_empty", 32'(empty), 1);

        // 5: pop in the very cycle of a push into a full FIFO
        for (int i = 0; i < DEPTH; i++) begin
            q.push_back(8'(8'h20 + i));
            send(8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
        end
        check("t5_full", 32'(full), 1);
        ov0 = n_ov;
        q.push_back(8'h30);
        fork
            send(8'h30, 1'b1, 1'b0, 1'b0);
            begin
                k = 0;
                while (busy !== 1'b1 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                check("t5_busy_rise", 32'(busy), 1);
                repeat (PUSH_OFS - 1) @(negedge clk);
                do_read("t5_pop");
            end
        join
        repeat (4) @(negedge clk);
        check("t5_no_overrun", 32'(n_ov - ov0), 0);
        check("t5_count", 32'(count), 16);
        for (int i = 0; i < DEPTH; i++) do_read("t5_rd");
        check("t5_empty", 32'(empty), 1);

`ifdef UART_RX_PARITY_EN
        // 6a: even parity good and bad
        q.push_back(8'h41);
        send(8'h41, 1'b1, 1'b0, 1'b1);
        check("t6_good_count", 32'(count), 1);
        check("t6_no_perr", 32'(n_pe), 0);
        do_read("t6_rd");
        send(8'h41, 1'b1, 1'b1, 1'b1);
        check("t6_perr", 32'(n_pe), 1);
        check("t6_bad_count", 32'(count), 0);
`endif

        // 6b: reset in the middle of a data bit
        q.push_back(8'h41);
        send(8'h41, 1'b1, 1'b0, 1'b0);
        check("t6_pre_count", 32'(count), 1);
        fork
            send(8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                repeat (CPB * 3 + CPB / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("t6_rst_busy", 32'(busy), 0);
                check("t6_rst_empty", 32'(empty), 1);
                check("t6_rst_count", 32'(count), 0);
                q.delete();
            end
        join
        repeat (40) @(negedge clk);
        check("t6_abandoned", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
